shift_norm_sched: RTL and testbench

Sequencer and arbiter that shares one 5-stage left barrel shifter among NREQ requesters. The shifter takes a 5-bit shift amount (0..31 per pass). Requested shift amounts span 0..WIDTH-1, so amounts above 31 need two passes. The block grants requesters round-robin, runs one or two passes, and holds the result in an output register with valid/ready handshake. It sits in the multiplier normalisation path, after leading-zero counting.

---
 rtl/shift_norm_pkg.sv | 26 ++
 rtl/shift_norm_sched_lshift.sv | 21 ++
 rtl/shift_norm_sched_rr_arbiter.sv | 31 +++
 rtl/shift_norm_sched.sv | 150 +++++++++++++++
 tb/tb_shift_norm_sched.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_norm_pkg.sv
// Shared types and helpers for the shift normalisation sequencer.
// The split helper divides a requested left shift into a first pass and a remainder.
package shift_norm_pkg;

    typedef enum logic {IDLE, PASS2} state_e;

    localparam int SPLIT_W = 7;

    typedef struct packed {
        logic [SPLIT_W-1:0] p1;
        logic [SPLIT_W-1:0] r;
    } pass_split_t;

    function automatic int pmax_of(input int width);
        return (1 << ($clog2(width) - 1)) - 1;
    endfunction

    function automatic pass_split_t clamp_pass(input logic [SPLIT_W-1:0] shamt,
                                               input logic [SPLIT_W-1:0] pmax);
        pass_split_t s;
        s.p1 = (shamt > pmax) ? pmax : shamt;
        s.r  = shamt - s.p1;
        return s;
    endfunction

endpackage

// File: rtl/shift_norm_sched_lshift.sv
// Logarithmic left barrel shifter, zero fill; one stage per amount bit.
module lshift_barrel #(
    parameter int WIDTH  = 48,
    parameter int AWIDTH = 5
) (
    input  logic [WIDTH-1:0]  din_i,
    input  logic [AWIDTH-1:0] amt_i,
    output logic [WIDTH-1:0]  dout_o
);

    logic [WIDTH-1:0] stg [AWIDTH+1];

    assign stg[0] = din_i;

    for (genvar k = 0; k < AWIDTH; k++) begin : g_stage
        assign stg[k+1] = amt_i[k] ? (stg[k] << (2 ** k)) : stg[k];
    end

    assign dout_o = stg[AWIDTH];

endmodule

// File: rtl/shift_norm_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after ptr_i,
// wrapping around. The pointer itself lives in the parent.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o
);

    always_comb begin
        logic found;
        int   c;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        c       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            c = (int'(ptr_i) + k) % NREQ;
            if (en_i && !found && req_i[c]) begin
                found      = 1'b1;
                grant_o[c] = 1'b1;
                idx_o      = IDW'(c);
            end
        end
    end

endmodule

// File: rtl/shift_norm_sched.sv
// Shares one 5-bit-amount left shifter among NREQ requesters; shifts above the
// per-pass maximum take a second pass through the same shifter.
module shift_norm_sched
    import shift_norm_pkg::*;
#(
    parameter  int WIDTH  = 48,
    parameter  int NREQ   = 2,
    localparam int SWIDTH = $clog2(WIDTH),
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WIDTH-1:0]  req_data,
    input  logic [NREQ*SWIDTH-1:0] req_shamt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [IDW-1:0]         out_id,
    output logic                   busy
);

    localparam int AWIDTH = $clog2(WIDTH) - 1;
    localparam int PMAX   = pmax_of(WIDTH);

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [IDW-1:0]     out_id_q, out_id_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [AWIDTH-1:0]  rem_q, rem_d;
    logic               out_valid_q, out_valid_d;

    logic               slot_free, arb_en;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     gidx;
    logic [SWIDTH-1:0]  cur_shamt;
    pass_split_t        split;
    logic               oversize;
    logic [WIDTH-1:0]   sh_in, sh_out;
    logic [AWIDTH-1:0]  sh_amt;

    logic [WIDTH-1:0]   req_data_a  [NREQ];
    logic [SWIDTH-1:0]  req_shamt_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_data_a[i]  = req_data[i*WIDTH +: WIDTH];
        assign req_shamt_a[i] = req_shamt[i*SWIDTH +: SWIDTH];
    end

    assign slot_free = !out_valid_q || out_ready;
    assign arb_en    = (state_q == IDLE) && slot_free;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .en_i    (arb_en),
        .grant_o (grant),
        .idx_o   (gidx)
    );

    assign cur_shamt = req_shamt_a[gidx];
    assign split     = clamp_pass(SPLIT_W'(cur_shamt), SPLIT_W'(PMAX));
    assign oversize  = SPLIT_W'(cur_shamt) >= SPLIT_W'(WIDTH);

    // The first pass amount never exceeds PMAX, so its top bits are always zero.
    logic unused_p1_hi;
    assign unused_p1_hi = ^split.p1[SPLIT_W-1:AWIDTH];

    assign sh_in  = (state_q == PASS2) ? work_q : req_data_a[gidx];
    assign sh_amt = (state_q == PASS2) ? rem_q  : split.p1[AWIDTH-1:0];

    lshift_barrel #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) u_shift (
        .din_i  (sh_in),
        .amt_i  (sh_amt),
        .dout_o (sh_out)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        work_d      = work_q;
        rem_d       = rem_q;
        id_d        = id_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    rr_ptr_d = gidx;
                    if (oversize) begin
                        out_data_d  = '0;
                        out_id_d    = gidx;
                        out_valid_d = 1'b1;
                    end else if (split.r == '0) begin
                        out_data_d  = sh_out;
                        out_id_d    = gidx;
                        out_valid_d = 1'b1;
                    end else begin
                        work_d  = sh_out;
                        rem_d   = split.r[AWIDTH-1:0];
                        id_d    = gidx;
                        state_d = PASS2;
                    end
                end
            end
            PASS2: begin
                if (slot_free) begin
                    out_data_d  = sh_out;
                    out_id_d    = id_q;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            id_q        <= '0;
            work_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign req_ready = grant;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign busy      = (state_q == PASS2);

endmodule

// File: tb/tb_shift_norm_sched.sv
// Bench for shift_norm_sched: transaction-level model checked every cycle plus
// directed literal expectations.
module tb_shift_norm_sched;

    localparam int W  = 48;
    localparam int N  = 2;
    localparam int SW = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_data = '0;
    logic [N*SW-1:0]   req_shamt = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [W-1:0]      out_data;
    logic [0:0]        out_id;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    shift_norm_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shamt (req_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [W-1:0] d, input logic [SW-1:0] s);
        req_valid[i]          = v;
        req_data[i*W +: W]    = d;
        req_shamt[i*SW +: SW] = s;
    endtask

    // Model: a result is data<<shamt (0 if shamt>=W); shamt 32..W-1 spends one
    // extra cycle in a busy second pass. Grants are round-robin after the last accept.
    logic         m_ov, m_busy;
    logic [W-1:0] m_od, m_pd;
    int           m_oid, m_pid, m_ptr;

    always @(negedge clk) begin
        int           g;
        logic         free;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] d, res;
        int           s;
        if (rst) begin
            m_ov = 0; m_busy = 0; m_od = '0; m_pd = '0;
            m_oid = 0; m_pid = 0; m_ptr = N - 1;
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
        end else begin
            free = !m_ov || out_ready;
            g = -1;
            if (!m_busy && free)
                for (int k = 1; k <= N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            exp_rdy = (g >= 0) ? N'(1 << g) : '0;
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            check("busy", 64'(busy), 64'(m_busy));
            check("out_valid", 64'(out_valid), 64'(m_ov));
            if (m_ov) begin
                check("out_data", 64'(out_data), 64'(m_od));
                check("out_id", 64'(out_id), 64'(m_oid));
            end
            if (m_busy) begin
                if (free) begin
                    m_ov = 1; m_od = m_pd; m_oid = m_pid; m_busy = 0;
                end
            end else begin
                if (out_ready) m_ov = 0;
                if (g >= 0) begin
                    m_ptr = g;
                    d = req_data[g*W +: W];
                    s = int'(req_shamt[g*SW +: SW]);
                    res = (s >= W) ? '0 : (d << s);
                    if (s > 31 && s < W) begin
                        m_busy = 1; m_pd = res; m_pid = g;
                    end else begin
                        m_ov = 1; m_od = res; m_oid = g;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input int i, input logic [W-1:0] d, input logic [SW-1:0] s,
                           input logic [W-1:0] exp, input logic exp_busy, input string name);
        set_req(i, 1'b1, d, s);
        tick();
        req_valid = '0;
        check({name, "_busy"}, 64'(busy), 64'(exp_busy));
        if (exp_busy) tick();
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_data"}, 64'(out_data), 64'(exp));
        check({name, "_id"}, 64'(out_id), 64'(i));
    endtask

    initial begin
        logic [0:0] rr_exp [4];
        rr_exp[0] = 1'b0; rr_exp[1] = 1'b1; rr_exp[2] = 1'b0; rr_exp[3] = 1'b1;

        repeat (2) tick();
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_id", 64'(out_id), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        tick();

        // single short shift
        run_one(0, 48'h0000_0000_00FF, 6'd8, 48'h0000_0000_FF00, 1'b0, "short");
        // two-pass shift
        run_one(1, 48'h1, 6'd40, 48'h0100_0000_0000, 1'b1, "twopass");
        check("twopass_busy_clear", 64'(busy), 64'd0);

        // round-robin with both requesters held
        set_req(0, 1'b1, 48'h3, 6'd1);
        set_req(1, 1'b1, 48'h5, 6'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_id", 64'(out_id), 64'(rr_exp[i]));
            check("rr_data", 64'(out_data), rr_exp[i] ? 64'h000A : 64'h0006);
        end
        req_valid = '0;
        tick();

        // backpressure: held result, blocked request, drain-and-replace
        out_ready = 1'b0;
        set_req(0, 1'b1, 48'h1, 6'd4);
        tick();
        req_valid = '0;
        set_req(1, 1'b1, 48'h1, 6'd3);
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", 64'(req_ready), 64'd0);
            tick();
            check("bp_hold_data", 64'(out_data), 64'h10);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        req_valid = '0;
        check("bp_replace_data", 64'(out_data), 64'h8);
        check("bp_replace_id", 64'(out_id), 64'd1);
        check("bp_replace_valid", 64'(out_valid), 64'd1);

        // boundary amounts
        run_one(0, 48'h1234_5678_9ABC, 6'd0, 48'h1234_5678_9ABC, 1'b0, "sh0");
        run_one(1, 48'h1, 6'd31, 48'h0000_8000_0000, 1'b0, "sh31");
        run_one(0, 48'h1, 6'd32, 48'h0001_0000_0000, 1'b1, "sh32");
        run_one(1, 48'h1, 6'd47, 48'h8000_0000_0000, 1'b1, "sh47");
        run_one(0, 48'hFFFF_FFFF_FFFF, 6'd48, 48'h0, 1'b0, "sh48");

        // asynchronous reset while in the second pass
        set_req(1, 1'b1, 48'h1, 6'd40);
        tick();
        req_valid = '0;
        check("prereset_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_busy", 64'(busy), 64'd0);
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_data", 64'(out_data), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        set_req(0, 1'b1, 48'h1, 6'd2);
        set_req(1, 1'b1, 48'h2, 6'd2);
        #1;
        check("post_reset_grant", 64'(req_ready), 64'd1);
        tick();
        req_valid = '0;
        check("post_reset_id", 64'(out_id), 64'd0);
        check("post_reset_data", 64'(out_data), 64'h4);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
